i2s_rx: RTL and testbench

I2S_RX -- requirements
Module: i2s_rx

---
 rtl/i2s_rx_if.sv | 36 +++
 rtl/i2s_rx.sv | 127 ++++++++++++
 tb/tb_i2s_rx.sv | 379 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/i2s_rx_if.sv
// I2S receiver bus: synchronized serial inputs in,
// assembled stereo samples and status pulses out.
interface i2s_rx_if #(
    parameter int DATA_WIDTH = 16
);
    logic                  bclk_rise;
    logic                  lrc_rise;
    logic                  lrc_fall;
    logic                  adcdat;
    logic [DATA_WIDTH-1:0] left_data;
    logic [DATA_WIDTH-1:0] right_data;
    logic                  data_valid;
    logic                  frame_err;

    modport master (
        output bclk_rise,
        output lrc_rise,
        output lrc_fall,
        output adcdat,
        input  left_data,
        input  right_data,
        input  data_valid,
        input  frame_err
    );

    modport slave (
        input  bclk_rise,
        input  lrc_rise,
        input  lrc_fall,
        input  adcdat,
        output left_data,
        output right_data,
        output data_valid,
        output frame_err
    );
endinterface

// File: rtl/i2s_rx.sv
// I2S ADC receiver: deserializes left/right words
// and publishes them as a pair once both are whole.
module i2s_rx #(
    parameter int DATA_WIDTH = 16
) (
    input logic  clk_in,
    input logic  rst_n,
    i2s_rx_if.slave bus
);
    localparam int W = DATA_WIDTH;
    localparam logic [5:0] LAST = 6'(DATA_WIDTH);

    typedef enum logic [1:0] {
        IDLE,
        SKIP,
        SHIFT,
        HOLD
    } state_t;

    state_t         state_q, state_d;
    logic           ch_q, ch_d;
    logic [5:0]     cnt_q, cnt_d;
    logic           left_ok_q, left_ok_d;
    logic [W-1:0]   lsr_q, lsr_d;
    logic [W-1:0]   rsr_q, rsr_d;
    logic [W-1:0]   ldat_q, ldat_d;
    logic [W-1:0]   rdat_q, rdat_d;
    logic           valid_q, valid_d;
    logic           ferr_q, ferr_d;

    logic [5:0]     cnt_inc;
    logic           in_word;
    logic           any_edge;
    logic           both_edge;

    // Next state: LRC edges win over bclk; slot bits past the word drop.
    always_comb begin
        state_d   = state_q;
        ch_d      = ch_q;
        cnt_d     = cnt_q;
        left_ok_d = left_ok_q;
        lsr_d     = lsr_q;
        rsr_d     = rsr_q;
        ldat_d    = ldat_q;
        rdat_d    = rdat_q;
        valid_d   = 1'b0;
        ferr_d    = 1'b0;

        cnt_inc   = (cnt_q == 6'h3F) ? cnt_q : cnt_q + 6'd1;
        in_word   = (state_q == SKIP) || (state_q == SHIFT);
        any_edge  = bus.lrc_rise | bus.lrc_fall;
        both_edge = bus.lrc_rise & bus.lrc_fall;

        if (both_edge) begin
            ferr_d    = 1'b1;
            state_d   = IDLE;
            cnt_d     = 6'd0;
            left_ok_d = 1'b0;
        end else if (any_edge) begin
            ferr_d  = in_word;
            if (in_word || bus.lrc_fall) begin
                left_ok_d = 1'b0;
            end
            state_d = SKIP;
            ch_d    = bus.lrc_rise;
            cnt_d   = 6'd0;
        end else if (bus.bclk_rise) begin
            unique case (state_q)
                SKIP: begin
                    state_d = SHIFT;
                    cnt_d   = 6'd0;
                end
                SHIFT: begin
                    cnt_d = cnt_inc;
                    if (ch_q) begin
                        rsr_d = {rsr_q[W-2:0], bus.adcdat};
                    end else begin
                        lsr_d = {lsr_q[W-2:0], bus.adcdat};
                    end
                    if (cnt_inc == LAST) begin
                        state_d = HOLD;
                        if (!ch_q) begin
                            left_ok_d = 1'b1;
                        end else if (left_ok_q) begin
                            valid_d = 1'b1;
                            ldat_d  = lsr_q;
                            rdat_d  = rsr_d;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            ch_q      <= 1'b0;
            cnt_q     <= 6'd0;
            left_ok_q <= 1'b0;
            lsr_q     <= '0;
            rsr_q     <= '0;
            ldat_q    <= '0;
            rdat_q    <= '0;
            valid_q   <= 1'b0;
            ferr_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            ch_q      <= ch_d;
            cnt_q     <= cnt_d;
            left_ok_q <= left_ok_d;
            lsr_q     <= lsr_d;
            rsr_q     <= rsr_d;
            ldat_q    <= ldat_d;
            rdat_q    <= rdat_d;
            valid_q   <= valid_d;
            ferr_q    <= ferr_d;
        end
    end

    assign bus.left_data  = ldat_q;
    assign bus.right_data = rdat_q;
    assign bus.data_valid = valid_q;
    assign bus.frame_err  = ferr_q;
endmodule

// File: tb/tb_i2s_rx.sv
// Bench for i2s_rx: 16- and 24-bit receivers share one
// serial stream and are checked against a slot-level model.
module tb_i2s_rx;
    logic clk;
    logic rst_n;
    logic bclk_rise;
    logic lrc_rise;
    logic lrc_fall;
    logic adcdat;

    int n_cmp;
    int n_err;

    initial clk = 1'b0;
    always #10 clk = ~clk;

    i2s_rx_if #(.DATA_WIDTH(16)) if16 ();
    i2s_rx_if #(.DATA_WIDTH(24)) if24 ();

    assign if16.bclk_rise = bclk_rise;
    assign if16.lrc_rise  = lrc_rise;
    assign if16.lrc_fall  = lrc_fall;
    assign if16.adcdat    = adcdat;
    assign if24.bclk_rise = bclk_rise;
    assign if24.lrc_rise  = lrc_rise;
    assign if24.lrc_fall  = lrc_fall;
    assign if24.adcdat    = adcdat;

    i2s_rx #(.DATA_WIDTH(16)) dut16 (
        .clk_in (clk),
        .rst_n  (rst_n),
        .bus    (if16)
    );

    i2s_rx #(.DATA_WIDTH(24)) dut24 (
        .clk_in (clk),
        .rst_n  (rst_n),
        .bus    (if24)
    );

    logic [31:0] obs_l [2];
    logic [31:0] obs_r [2];
    logic        obs_dv [2];
    logic        obs_fe [2];

    assign obs_l[0]  = {16'd0, if16.left_data};
    assign obs_r[0]  = {16'd0, if16.right_data};
    assign obs_l[1]  = {8'd0, if24.left_data};
    assign obs_r[1]  = {8'd0, if24.right_data};
    assign obs_dv[0] = if16.data_valid;
    assign obs_dv[1] = if24.data_valid;
    assign obs_fe[0] = if16.frame_err;
    assign obs_fe[1] = if24.frame_err;

    int dvc [2];
    int fec [2];

    // Pulse counters, sampled mid-cycle.
    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (obs_dv[i]) dvc[i]++;
            if (obs_fe[i]) fec[i]++;
        end
    end

    // Slot-level reference model, one per word width.
    typedef struct {
        bit          active;
        bit          ch;
        bit          done;
        bit          left_ok;
        logic [31:0] lw;
        logic [31:0] el;
        logic [31:0] er;
        int          dv;
        int          fe;
    } mdl_t;

    mdl_t m [2];

    typedef struct {
        logic [31:0] l;
        logic [31:0] r;
        int          nl;
        int          nr;
        bit          coin;
        int          dv;
        int          fe;
        logic [15:0] el;
        logic [15:0] er;
    } vec_t;

    vec_t tbl [8];

    function automatic int wid(input int i);
        return (i == 0) ? 16 : 24;
    endfunction

    // Rise k of a slot carries b[63-k]; rise 0 is the delay slot.
    function automatic logic [63:0] mk(
        input logic [31:0] w,
        input int          wd,
        input logic [63:0] junk
    );
        logic [63:0] b;
        b = junk;
        for (int i = 0; i < wd; i++) b[62-i] = w[wd-1-i];
        return b;
    endfunction

    function automatic logic [31:0] word_of(
        input logic [63:0] b,
        input int          w
    );
        logic [63:0] t;
        t = b >> (63 - w);
        return 32'(t & ((64'd1 << w) - 64'd1));
    endfunction

    function automatic logic [63:0] rnd64();
        return {$urandom, $urandom};
    endfunction

    task automatic chk(
        input string       nm,
        input logic [63:0] act,
        input logic [63:0] exp
    );
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic m_edge(input bit r, input bit f);
        for (int i = 0; i < 2; i++) begin
            if (r && f) begin
                m[i].fe++;
                m[i].active  = 1'b0;
                m[i].left_ok = 1'b0;
            end else begin
                if (m[i].active && !m[i].done) begin
                    m[i].fe++;
                    m[i].left_ok = 1'b0;
                end
                if (f) m[i].left_ok = 1'b0;
                m[i].active = 1'b1;
                m[i].ch     = r;
                m[i].done   = 1'b0;
            end
        end
    endtask

    task automatic m_rises(input logic [63:0] b, input int n);
        logic [31:0] wd;
        for (int i = 0; i < 2; i++) begin
            if (m[i].active && !m[i].done && n >= wid(i) + 1) begin
                m[i].done = 1'b1;
                wd = word_of(b, wid(i));
                if (!m[i].ch) begin
                    m[i].left_ok = 1'b1;
                    m[i].lw      = wd;
                end else if (m[i].left_ok) begin
                    m[i].dv++;
                    m[i].el = m[i].lw;
                    m[i].er = wd;
                end
            end
        end
    endtask

    task automatic m_reset();
        for (int i = 0; i < 2; i++) begin
            m[i].active  = 1'b0;
            m[i].done    = 1'b0;
            m[i].left_ok = 1'b0;
            m[i].el      = '0;
            m[i].er      = '0;
        end
    endtask

    task automatic edge_pulse(input bit r, input bit f, input bit coin);
        @(negedge clk);
        lrc_rise  = r;
        lrc_fall  = f;
        bclk_rise = coin;
        adcdat    = 1'($urandom);
        @(negedge clk);
        lrc_rise  = 1'b0;
        lrc_fall  = 1'b0;
        bclk_rise = 1'b0;
    endtask

    task automatic rise(input logic d);
        @(negedge clk);
        bclk_rise = 1'b1;
        adcdat    = d;
        @(negedge clk);
        bclk_rise = 1'b0;
        adcdat    = 1'($urandom);
    endtask

    // One channel slot; at the final data bit of each width the
    // pair must already be published (one-cycle latency).
    task automatic slot(
        input bit          r,
        input logic [63:0] b,
        input int          n,
        input bit          coin
    );
        edge_pulse(r, !r, coin);
        m_edge(r, !r);
        for (int k = 0; k < n; k++) begin
            rise(b[63-k]);
            for (int i = 0; i < 2; i++) begin
                if (k == wid(i)) begin
                    chk($sformatf("w%0d latency", wid(i)),
                        64'(obs_dv[i]),
                        64'(m[i].ch && m[i].left_ok));
                end
            end
        end
        m_rises(b, n);
    endtask

    task automatic frame(
        input logic [63:0] lb,
        input logic [63:0] rb,
        input int          nl,
        input int          nr,
        input bit          coin
    );
        slot(1'b0, lb, nl, coin);
        slot(1'b1, rb, nr, coin);
    endtask

    task automatic settle();
        repeat (2) @(negedge clk);
        #1;
    endtask

    task automatic check_model(input string tag);
        settle();
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("%s w%0d dv_count", tag, wid(i)),
                64'(dvc[i]), 64'(m[i].dv));
            chk($sformatf("%s w%0d fe_count", tag, wid(i)),
                64'(fec[i]), 64'(m[i].fe));
            chk($sformatf("%s w%0d left", tag, wid(i)),
                64'(obs_l[i]), 64'(m[i].el));
            chk($sformatf("%s w%0d right", tag, wid(i)),
                64'(obs_r[i]), 64'(m[i].er));
        end
    endtask

    task automatic check_zero(input string tag);
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("%s w%0d left", tag, wid(i)),
                64'(obs_l[i]), 64'd0);
            chk($sformatf("%s w%0d right", tag, wid(i)),
                64'(obs_r[i]), 64'd0);
            chk($sformatf("%s w%0d dv", tag, wid(i)),
                64'(obs_dv[i]), 64'd0);
            chk($sformatf("%s w%0d fe", tag, wid(i)),
                64'(obs_fe[i]), 64'd0);
        end
    endtask

    initial begin
        int dv0;
        int fe0;
        int nl;
        int nr;

        n_cmp     = 0;
        n_err     = 0;
        rst_n     = 1'b0;
        bclk_rise = 1'b0;
        lrc_rise  = 1'b0;
        lrc_fall  = 1'b0;
        adcdat    = 1'b0;
        m_reset();
        for (int i = 0; i < 2; i++) begin
            m[i].dv = 0;
            m[i].fe = 0;
        end

        tbl[0] = '{32'hA55A, 32'h1234, 32, 32, 1'b0, 1, 0,
                   16'hA55A, 16'h1234};
        tbl[1] = '{32'h5555, 32'hF0F0, 11, 32, 1'b0, 0, 1,
                   16'hA55A, 16'h1234};
        tbl[2] = '{32'h0F0F, 32'hF0F0, 32, 32, 1'b0, 1, 0,
                   16'h0F0F, 16'hF0F0};
        tbl[3] = '{32'hC3A5, 32'h5AC3, 32, 32, 1'b1, 1, 0,
                   16'hC3A5, 16'h5AC3};
        tbl[4] = '{32'h0001, 32'h0002, 32, 32, 1'b0, 1, 0,
                   16'h0001, 16'h0002};
        tbl[5] = '{32'hFFFF, 32'h8000, 32, 32, 1'b0, 1, 0,
                   16'hFFFF, 16'h8000};
        tbl[6] = '{32'h1357, 32'h2468, 17, 17, 1'b0, 1, 0,
                   16'h1357, 16'h2468};
        tbl[7] = '{32'hBEEF, 32'hCAFE, 16, 32, 1'b0, 0, 1,
                   16'h1357, 16'h2468};

        repeat (3) @(negedge clk);
        check_zero("reset");
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        for (int v = 0; v < 8; v++) begin
            dv0 = dvc[0];
            fe0 = fec[0];
            frame(mk(tbl[v].l, 16, rnd64()),
                  mk(tbl[v].r, 16, rnd64()),
                  tbl[v].nl, tbl[v].nr, tbl[v].coin);
            settle();
            chk($sformatf("row%0d dv", v),
                64'(dvc[0] - dv0), 64'(tbl[v].dv));
            chk($sformatf("row%0d fe", v),
                64'(fec[0] - fe0), 64'(tbl[v].fe));
            chk($sformatf("row%0d left", v),
                64'(if16.left_data), 64'(tbl[v].el));
            chk($sformatf("row%0d right", v),
                64'(if16.right_data), 64'(tbl[v].er));
            check_model($sformatf("row%0d", v));
        end

        dv0 = dvc[1];
        frame(mk(32'h800001, 24, '1),
              mk(32'h7FFFFE, 24, '1), 32, 32, 1'b0);
        settle();
        chk("w24 junk dv", 64'(dvc[1] - dv0), 64'd1);
        chk("w24 junk left", 64'(if24.left_data), 64'h800001);
        chk("w24 junk right", 64'(if24.right_data), 64'h7FFFFE);
        check_model("w24 junk");

        fe0 = fec[0];
        dv0 = dvc[0];
        edge_pulse(1'b1, 1'b1, 1'b0);
        m_edge(1'b1, 1'b1);
        slot(1'b1, rnd64(), 32, 1'b0);
        settle();
        chk("both edges fe", 64'(fec[0] - fe0), 64'd1);
        chk("both edges dv", 64'(dvc[0] - dv0), 64'd0);
        check_model("both edges");
        frame(rnd64(), rnd64(), 32, 32, 1'b0);
        check_model("after both");

        slot(1'b0, rnd64(), 32, 1'b0);
        edge_pulse(1'b1, 1'b0, 1'b0);
        m_edge(1'b1, 1'b0);
        for (int k = 0; k < 10; k++) rise(1'($urandom));
        @(negedge clk);
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check_zero("mid reset");
        m_reset();
        rst_n = 1'b1;
        for (int k = 0; k < 22; k++) rise(1'($urandom));
        check_model("post reset tail");
        slot(1'b1, rnd64(), 32, 1'b0);
        check_model("post reset right");
        frame(rnd64(), rnd64(), 32, 32, 1'b0);
        check_model("post reset frame");

        for (int f = 0; f < 40; f++) begin
            nl = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 40) : 32;
            nr = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 40) : 32;
            frame(rnd64(), rnd64(), nl, nr,
                  ($urandom_range(0, 3) == 0));
            check_model($sformatf("rand%0d", f));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end
endmodule
